// File: rtl/to_hw_pkg.sv
// Shared types and constants for the software-to-hardware port bank.
// Holds the commit state encoding, the CTRL bit map and register offsets.
package to_hw_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_e;

  localparam int CTRL_COMMIT    = 0;
  localparam int CTRL_SYNC_MODE = 1;
  localparam int CTRL_PENDING   = 2;

  localparam int COUNT_W = 16;

  // Register offsets counted from the first address past the last channel
  localparam int CTRL_OFS  = 0;
  localparam int COUNT_OFS = 1;

endpackage

// File: rtl/to_hw_commit_fsm.sv
// Commit sequencer: turns CTRL commit requests into one apply pulse.
// Either applies immediately or waits in PENDING for the next frame_sync.
module to_hw_commit_fsm
  import to_hw_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic commit_req_i,
  input  logic sync_mode_i,
  input  logic frame_sync_i,
  output logic apply_o,
  output logic pending_o
);

  commit_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // frame_sync only matters once PENDING, so a coincident pulse in IDLE is dropped
  always_comb begin
    state_d = state_q;
    apply_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req_i) begin
          if (sync_mode_i) state_d = PENDING;
          else             apply_o = 1'b1;
        end
      end
      PENDING: begin
        if (frame_sync_i) begin
          apply_o = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_o = (state_q == PENDING);

endmodule

// File: rtl/to_hw_port_bank.sv
// Avalon-MM bank of double-buffered output channels with readback,
// byte-lane writes and atomic (optionally frame-aligned) commit.
module to_hw_port_bank
  import to_hw_pkg::*;
#(
  parameter int              NUM_PORTS = 10,
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [ADDR_W-1:0]           avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  input  logic [3:0]                  avs_byteenable,
  output logic [31:0]                 avs_readdata,
  input  logic                        frame_sync,
  output logic [NUM_PORTS*DATA_W-1:0] to_hw_export,
  output logic                        to_hw_update
);

  if (NUM_PORTS < 1 || NUM_PORTS > 62) begin : g_bad_ports
    $error("to_hw_port_bank: NUM_PORTS must be 1..62");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("to_hw_port_bank: DATA_W must be 1..32");
  end
  if ((2 ** ADDR_W) < NUM_PORTS + 2) begin : g_bad_addr
    $error("to_hw_port_bank: ADDR_W too small for channels plus CTRL and COUNT");
  end

  localparam logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(NUM_PORTS + CTRL_OFS);
  localparam logic [ADDR_W-1:0] COUNT_ADDR = ADDR_W'(NUM_PORTS + COUNT_OFS);

  logic [NUM_PORTS-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] live_q, live_d;
  logic [COUNT_W-1:0]               count_q, count_d;
  logic                             sync_mode_q, sync_mode_d;
  logic [31:0]                      rdata_q, rdata_d;
  logic                             update_q;
  logic                             ctrl_wr, commit_req, apply, pending;
  logic [31:0]                      rmux;

  assign ctrl_wr    = avs_write && (avs_address == CTRL_ADDR);
  assign commit_req = ctrl_wr && avs_writedata[CTRL_COMMIT];

  // The sync_mode bit written alongside the commit decides how that commit is handled
  to_hw_commit_fsm u_fsm (
    .clk_i        (clk_clk),
    .rst_i        (reset_reset),
    .commit_req_i (commit_req),
    .sync_mode_i  (avs_writedata[CTRL_SYNC_MODE]),
    .frame_sync_i (frame_sync),
    .apply_o      (apply),
    .pending_o    (pending)
  );

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (avs_write && avs_address == ADDR_W'(k)) begin
        for (int b = 0; b < DATA_W; b++) begin
          if (avs_byteenable[b/8]) shadow_d[k][b] = avs_writedata[b];
        end
      end
    end
  end

  // live copies the pre-write shadow, so a write in the apply cycle waits for the next commit
  assign live_d      = apply ? shadow_q : live_q;
  assign count_d     = apply ? count_q + COUNT_W'(1) : count_q;
  assign sync_mode_d = ctrl_wr ? avs_writedata[CTRL_SYNC_MODE] : sync_mode_q;

  always_comb begin
    rmux = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (avs_address == ADDR_W'(k)) rmux = 32'(shadow_q[k]);
    end
    if (avs_address == CTRL_ADDR) begin
      rmux[CTRL_SYNC_MODE] = sync_mode_q;
      rmux[CTRL_PENDING]   = pending;
    end
    if (avs_address == COUNT_ADDR) rmux = 32'(count_q);
  end

  assign rdata_d = avs_read ? rmux : rdata_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      shadow_q    <= {NUM_PORTS{RESET_VAL}};
      live_q      <= {NUM_PORTS{RESET_VAL}};
      count_q     <= '0;
      sync_mode_q <= 1'b0;
      rdata_q     <= '0;
      update_q    <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      live_q      <= live_d;
      count_q     <= count_d;
      sync_mode_q <= sync_mode_d;
      rdata_q     <= rdata_d;
      update_q    <= apply;
    end
  end

  assign to_hw_export = live_q;
  assign to_hw_update = update_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_to_hw_port_bank.sv
// Bench for to_hw_port_bank: a wide default instance and a narrow 3x8-bit
// instance, both compared against a register-level reference model.
module tb_to_hw_port_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: defaults
  logic        a_rst, a_rd, a_wr, a_fs, a_upd;
  logic [3:0]  a_addr, a_be;
  logic [31:0] a_wd, a_rdata;
  logic [319:0] a_exp;
  // instance B: 3 ports x 8 bits, non-zero reset value
  logic        b_rst, b_rd, b_wr, b_fs, b_upd;
  logic [2:0]  b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wd, b_rdata;
  logic [23:0] b_exp;

  to_hw_port_bank dut_a (
    .clk_clk(clk), .reset_reset(a_rst), .avs_address(a_addr), .avs_read(a_rd),
    .avs_write(a_wr), .avs_writedata(a_wd), .avs_byteenable(a_be),
    .avs_readdata(a_rdata), .frame_sync(a_fs), .to_hw_export(a_exp), .to_hw_update(a_upd)
  );

  to_hw_port_bank #(.NUM_PORTS(3), .DATA_W(8), .ADDR_W(3), .RESET_VAL(8'hA5)) dut_b (
    .clk_clk(clk), .reset_reset(b_rst), .avs_address(b_addr), .avs_read(b_rd),
    .avs_write(b_wr), .avs_writedata(b_wd), .avs_byteenable(b_be),
    .avs_readdata(b_rdata), .frame_sync(b_fs), .to_hw_export(b_exp), .to_hw_update(b_upd)
  );

  int vec = 0;
  int errs = 0;

  // reference model state, indexed by instance
  logic [31:0] m_sh[2][10];
  logic [31:0] m_lv[2][10];
  bit          m_sync[2];
  bit          m_pend[2];
  int          m_cnt[2];
  logic [31:0] m_rd[2];
  bit          m_upd[2];

  function automatic int np(int sel);
    return (sel == 0) ? 10 : 3;
  endfunction

  function automatic int dw(int sel);
    return (sel == 0) ? 32 : 8;
  endfunction

  function automatic logic [319:0] exp_a();
    logic [319:0] v = '0;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = m_lv[0][k];
    return v;
  endfunction

  function automatic logic [23:0] exp_b();
    logic [23:0] v = '0;
    for (int k = 0; k < 3; k++) v[k*8 +: 8] = m_lv[1][k][7:0];
    return v;
  endfunction

  task automatic model_reset(int sel);
    for (int k = 0; k < 10; k++) begin
      m_sh[sel][k] = (sel == 0) ? 32'h0 : 32'hA5;
      m_lv[sel][k] = (sel == 0) ? 32'h0 : 32'hA5;
    end
    m_sync[sel] = 0; m_pend[sel] = 0; m_cnt[sel] = 0; m_rd[sel] = 0; m_upd[sel] = 0;
  endtask

  task automatic model_step(int sel, int a, bit rd, bit wr, logic [31:0] wd, logic [3:0] be, bit fs);
    int n = np(sel);
    logic [31:0] mask = (dw(sel) == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw(sel)) - 1);
    logic [31:0] bm;
    bit req, apply;
    if (rd) begin
      if (a < n)           m_rd[sel] = m_sh[sel][a];
      else if (a == n)     m_rd[sel] = {29'd0, m_pend[sel], m_sync[sel], 1'b0};
      else if (a == n + 1) m_rd[sel] = 32'(m_cnt[sel]);
      else                 m_rd[sel] = 32'd0;
    end
    req   = wr && (a == n) && wd[0];
    apply = m_pend[sel] ? fs : (req && !wd[1]);
    if (!m_pend[sel] && req && wd[1]) m_pend[sel] = 1;
    else if (m_pend[sel] && fs)       m_pend[sel] = 0;
    if (apply) begin
      for (int k = 0; k < n; k++) m_lv[sel][k] = m_sh[sel][k];
      m_cnt[sel] = (m_cnt[sel] + 1) % 65536;
    end
    if (wr && a < n) begin
      bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      m_sh[sel][a] = ((m_sh[sel][a] & ~bm) | (wd & bm)) & mask;
    end
    if (wr && a == n) m_sync[sel] = wd[1];
    m_upd[sel] = apply;
  endtask

  // one bus cycle on the chosen instance; the other sits idle
  task automatic cyc(int sel, int a, bit rd, bit wr, logic [31:0] wd, logic [3:0] be, bit fs);
    a_rd = 0; a_wr = 0; a_fs = 0; b_rd = 0; b_wr = 0; b_fs = 0;
    if (sel == 0) begin
      a_addr = 4'(a); a_rd = rd; a_wr = wr; a_wd = wd; a_be = be; a_fs = fs;
    end else begin
      b_addr = 3'(a); b_rd = rd; b_wr = wr; b_wd = wd; b_be = be; b_fs = fs;
    end
    @(posedge clk);
    model_step(sel, a, rd, wr, wd, be, fs);
    #1;
  endtask

  task automatic do_reset(int sel);
    a_rd = 0; a_wr = 0; a_fs = 0; b_rd = 0; b_wr = 0; b_fs = 0;
    if (sel == 0) a_rst = 1; else b_rst = 1;
    @(posedge clk);
    model_reset(sel);
    #1;
    a_rst = 0; b_rst = 0;
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1;
    a_addr = 0; a_wd = 0; a_be = 0; b_addr = 0; b_wd = 0; b_be = 0;
    do_reset(0);
    do_reset(1);
    vec++; if (a_exp !== 320'd0) begin errs++; $display("FAIL reset_export_a got %h want 0", a_exp); end
    vec++; if (a_rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata_a got %h want 0", a_rdata); end
    vec++; if (b_exp !== 24'hA5A5A5) begin errs++; $display("FAIL reset_export_b got %h want a5a5a5", b_exp); end
    for (int r = 0; r < 12; r++) begin
      cyc(0, r, 1, 0, 0, 0, 0);
      vec++;
      if (a_rdata !== 32'd0 || a_upd !== 1'b0) begin
        errs++; $display("FAIL reset_read addr %0d got %h upd %b want 0 upd 0", r, a_rdata, a_upd);
      end
    end
  endtask

  task automatic test_byte_lanes();
    cyc(0, 3, 0, 1, 32'hDEADBEEF, 4'b0101, 0);
    cyc(0, 3, 1, 0, 0, 0, 0);
    vec++; if (a_rdata !== 32'h00AD00EF) begin errs++; $display("FAIL byte_lane_read got %h want 00ad00ef", a_rdata); end
    vec++; if (a_exp !== exp_a() || a_exp[3*32 +: 32] !== 32'd0) begin
      errs++; $display("FAIL byte_lane_live_unchanged got %h want %h", a_exp[3*32 +: 32], 32'd0);
    end
  endtask

  task automatic test_commit_now();
    int pulses = 0;
    cyc(0, 0, 0, 1, 32'h12345678, 4'hF, 0);
    cyc(0, 10, 0, 1, 32'h1, 4'hF, 0);
    if (a_upd) pulses++;
    vec++; if (a_upd !== 1'b1 || a_exp[31:0] !== 32'h12345678) begin
      errs++; $display("FAIL commit_now upd %b ch0 %h want 1 12345678", a_upd, a_exp[31:0]);
    end
    vec++; if (a_exp[3*32 +: 32] !== 32'h00AD00EF) begin
      errs++; $display("FAIL commit_now_ch3 got %h want 00ad00ef", a_exp[3*32 +: 32]);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 11, 1, 0, 0, 0, 0);
      if (a_upd) pulses++;
    end
    vec++; if (pulses != 1) begin errs++; $display("FAIL commit_now_pulses got %0d want 1", pulses); end
    vec++; if (a_rdata !== 32'd1) begin errs++; $display("FAIL commit_now_count got %h want 1", a_rdata); end
  endtask

  task automatic test_sync_commit();
    int pulses = 0;
    cyc(0, 5, 0, 1, 32'hCAFE0005, 4'hF, 0);
    cyc(0, 10, 0, 1, 32'h3, 4'hF, 0);
    if (a_upd) pulses++;
    cyc(0, 10, 1, 1, 32'h3, 4'hF, 0);
    if (a_upd) pulses++;
    vec++; if (a_rdata !== 32'h6) begin errs++; $display("FAIL sync_ctrl_pending got %h want 6", a_rdata); end
    cyc(0, 10, 0, 1, 32'h3, 4'hF, 0);
    if (a_upd) pulses++;
    vec++; if (pulses != 0 || a_exp[5*32 +: 32] !== 32'd0) begin
      errs++; $display("FAIL sync_early_apply pulses %0d ch5 %h want 0 0", pulses, a_exp[5*32 +: 32]);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    vec++; if (a_upd !== 1'b1 || a_exp[5*32 +: 32] !== 32'hCAFE0005) begin
      errs++; $display("FAIL sync_apply upd %b ch5 %h want 1 cafe0005", a_upd, a_exp[5*32 +: 32]);
    end
    cyc(0, 10, 1, 0, 0, 0, 1);
    vec++; if (a_upd !== 1'b0 || a_rdata !== 32'h2) begin
      errs++; $display("FAIL sync_after upd %b ctrl %h want 0 2", a_upd, a_rdata);
    end
    cyc(0, 11, 1, 0, 0, 0, 0);
    vec++; if (a_rdata !== 32'd2) begin errs++; $display("FAIL sync_count got %h want 2", a_rdata); end
  endtask

  task automatic test_coincident_sync();
    cyc(0, 1, 0, 1, 32'h0000_0011, 4'hF, 0);
    cyc(0, 10, 0, 1, 32'h3, 4'hF, 1);
    vec++; if (a_upd !== 1'b0) begin errs++; $display("FAIL coincident_ignored upd %b want 0", a_upd); end
    cyc(0, 10, 1, 0, 0, 0, 0);
    vec++; if (a_upd !== 1'b0 || a_rdata !== 32'h6) begin
      errs++; $display("FAIL coincident_pending upd %b ctrl %h want 0 6", a_upd, a_rdata);
    end
    cyc(0, 1, 0, 1, 32'h0000_0022, 4'hF, 1);
    vec++; if (a_upd !== 1'b1 || a_exp[63:32] !== 32'h11) begin
      errs++; $display("FAIL coincident_apply upd %b ch1 %h want 1 11", a_upd, a_exp[63:32]);
    end
    cyc(0, 11, 1, 1, 32'h0, 4'hF, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    vec++; if (a_rdata !== 32'h22) begin errs++; $display("FAIL coincident_shadow got %h want 22", a_rdata); end
    cyc(0, 10, 0, 1, 32'h0, 4'hF, 0);
  endtask

  task automatic test_random();
    int a;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom % 4 == 0) ? 10 : int'($urandom_range(0, 15));
      cyc(0, a, bit'($urandom % 2), bit'($urandom % 3 == 0), $urandom, 4'($urandom),
          bit'($urandom % 5 == 0));
      vec++;
      if (a_upd !== m_upd[0] || a_exp !== exp_a() || a_rdata !== m_rd[0]) begin
        errs++;
        $display("FAIL random cyc %0d upd %b rd %h want upd %b rd %h export_ok %b",
                 i, a_upd, a_rdata, m_upd[0], m_rd[0], a_exp === exp_a());
      end
    end
  endtask

  task automatic test_narrow();
    cyc(1, 2, 0, 1, 32'hFFFF_FFFF, 4'hF, 0);
    cyc(1, 2, 1, 0, 0, 0, 0);
    vec++; if (b_rdata !== 32'h0000_00FF) begin errs++; $display("FAIL narrow_read got %h want ff", b_rdata); end
    cyc(1, 7, 0, 1, 32'h1234_5678, 4'hF, 0);
    cyc(1, 7, 1, 0, 0, 0, 0);
    vec++; if (b_rdata !== 32'd0) begin errs++; $display("FAIL narrow_unmapped got %h want 0", b_rdata); end
    cyc(1, 3, 0, 1, 32'h1, 4'hF, 0);
    vec++; if (b_upd !== 1'b1 || b_exp !== 24'hFFA5A5) begin
      errs++; $display("FAIL narrow_commit upd %b exp %h want 1 ffa5a5", b_upd, b_exp);
    end
    cyc(1, 3, 0, 1, 32'h3, 4'hF, 0);
    cyc(1, 3, 1, 0, 0, 0, 0);
    vec++; if (b_rdata !== 32'h6) begin errs++; $display("FAIL narrow_pending got %h want 6", b_rdata); end
    do_reset(1);
    vec++; if (b_exp !== 24'hA5A5A5 || b_rdata !== 32'd0 || b_exp !== exp_b()) begin
      errs++; $display("FAIL narrow_reset exp %h rd %h want a5a5a5 0", b_exp, b_rdata);
    end
    cyc(1, 3, 1, 0, 0, 0, 1);
    vec++; if (b_upd !== 1'b0 || b_rdata !== 32'd0 || b_exp !== 24'hA5A5A5) begin
      errs++; $display("FAIL narrow_no_apply upd %b ctrl %h exp %h want 0 0 a5a5a5", b_upd, b_rdata, b_exp);
    end
    cyc(1, 4, 1, 0, 0, 0, 0);
    vec++; if (b_rdata !== 32'd0) begin errs++; $display("FAIL narrow_count got %h want 0", b_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_lanes();
    test_commit_now();
    test_sync_commit();
    test_coincident_sync();
    test_random();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
